// File: rtl/fifo_arb_pkg.sv
// Shared definitions for the FIFO write arbiter.
//   N_REQ / DW / BURST : default producer count, word width and burst length
//   arb_state_e        : arbiter FSM encoding (IDLE = 0, GRANT = 1)
package fifo_arb_pkg;

  localparam int N_REQ = 4;
  localparam int DW    = 8;
  localparam int BURST = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Round-robin priority picker for four requesters (purely combinational).
//   req  [3:0] : request vector
//   last [1:0] : index of the most recent owner; search starts at last+1
//   pick [1:0] : first requesting index found in round-robin order (0 if none)
//   any        : at least one request bit is set
module rr_pick (
  input  logic [3:0] req,
  input  logic [1:0] last,
  output logic [1:0] pick,
  output logic       any
);

  logic [1:0] idx;
  logic       found;

  // Offsets 1..4 walk last+1 around to last itself; 2-bit wrap does the mod 4.
  always_comb begin
    pick  = 2'd0;
    found = 1'b0;
    idx   = 2'd0;
    for (int i = 1; i <= 4; i++) begin
      idx = last + 2'(i);
      if (!found && req[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
  end

  assign any = |req;

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Arbitrates four producers onto one FIFO write port, granting bursts of up
// to BURST beats in round-robin order with one idle cycle between grants.
//   clk, rst_n   : clock, asynchronous active-low reset
//   req_valid    : per-producer word available
//   req_data     : producer i word at [i*DW +: DW]
//   req_ready    : per-producer beat accepted (owner only, during a beat)
//   fifo_full    : downstream FIFO full; stalls grants and beats
//   fifo_wr_en   : FIFO write strobe
//   fifo_data    : FIFO write data (zero when not writing)
//   grant_id     : current owner, 0 when idle
//   busy         : high while a grant is active
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | no owner; pick next requester round-robin when FIFO not full
// GRANT | owner holds the port; beats while valid and FIFO not full
module fifo_wr_arbiter #(
  parameter int N_REQ = fifo_arb_pkg::N_REQ,
  parameter int DW    = fifo_arb_pkg::DW,
  parameter int BURST = fifo_arb_pkg::BURST
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [N_REQ-1:0]    req_valid,
  input  logic [N_REQ*DW-1:0] req_data,
  output logic [N_REQ-1:0]    req_ready,
  input  logic                fifo_full,
  output logic                fifo_wr_en,
  output logic [DW-1:0]       fifo_data,
  output logic [1:0]          grant_id,
  output logic                busy
);

  import fifo_arb_pkg::*;

  arb_state_e state_q, state_d;
  logic [1:0] owner_q, owner_d;
  logic [1:0] last_owner_q, last_owner_d;
  logic [2:0] beat_cnt_q, beat_cnt_d;

  logic [1:0] pick;
  logic       any_req;
  logic       owner_valid;
  logic       beat;

  rr_pick u_rr_pick (
    .req  (req_valid),
    .last (last_owner_q),
    .pick (pick),
    .any  (any_req)
  );

  assign owner_valid = req_valid[owner_q];
  assign beat        = (state_q == GRANT) && owner_valid && !fifo_full;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      owner_q      <= 2'd0;
      last_owner_q <= 2'd3;
      beat_cnt_q   <= 3'd0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      beat_cnt_q   <= beat_cnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    beat_cnt_d   = beat_cnt_q;
    case (state_q)
      IDLE: begin
        if (any_req && !fifo_full) begin
          state_d    = GRANT;
          owner_d    = pick;
          beat_cnt_d = 3'd0;
        end
      end
      GRANT: begin
        // A full FIFO freezes everything, including release.
        if (!fifo_full) begin
          if (!owner_valid || (beat_cnt_q == 3'(BURST - 1))) begin
            state_d      = IDLE;
            last_owner_d = owner_q;
            beat_cnt_d   = 3'd0;
          end else begin
            beat_cnt_d = beat_cnt_q + 3'd1;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs are gated by the registered state, so reset clears them at once.
  always_comb begin
    req_ready  = '0;
    fifo_wr_en = beat;
    fifo_data  = '0;
    if (beat) begin
      req_ready[owner_q] = 1'b1;
      fifo_data          = req_data[owner_q*DW +: DW];
    end
  end

  assign busy     = (state_q == GRANT);
  assign grant_id = busy ? owner_q : 2'd0;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
module tb_fifo_wr_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  req_valid = 4'b0000;
  logic [31:0] req_data = 32'h4433_2211;
  logic [3:0]  req_ready;
  logic        fifo_full = 1'b0;
  logic        fifo_wr_en;
  logic [7:0]  fifo_data;
  logic [1:0]  grant_id;
  logic        busy;

  int checks = 0;
  int errors = 0;

  fifo_wr_arbiter dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .fifo_full  (fifo_full),
    .fifo_wr_en (fifo_wr_en),
    .fifo_data  (fifo_data),
    .grant_id   (grant_id),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // {busy, fifo_wr_en, grant_id, req_ready, fifo_data}
  function automatic logic [15:0] outs();
    return {busy, fifo_wr_en, grant_id, req_ready, fifo_data};
  endfunction

  function automatic logic [15:0] ev(input logic b, input logic w, input logic [1:0] g,
                                     input logic [3:0] r, input logic [7:0] d);
    return {b, w, g, r, d};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req_valid = 4'b1111;
    fifo_full = 1'b0;
    tick();
    tick();
    #1;
    checks++;
    if (outs() !== 16'h0000) begin
      errors++;
      $display("FAIL reset_outputs got %h exp %h", outs(), 16'h0000);
    end
    req_valid = 4'b0000;
  endtask

  task automatic test_single();
    req_valid = 4'b0010;
    do_reset();
    #1;
    checks++;
    if (outs() !== 16'h0000) begin
      errors++;
      $display("FAIL single_c0 got %h exp %h", outs(), 16'h0000);
    end
    for (int c = 1; c <= 4; c++) begin
      tick();
      #1;
      checks++;
      if (outs() !== ev(1'b1, 1'b1, 2'd1, 4'b0010, 8'h22)) begin
        errors++;
        $display("FAIL single_beat%0d got %h exp %h", c, outs(), ev(1'b1, 1'b1, 2'd1, 4'b0010, 8'h22));
      end
    end
    tick();
    #1;
    checks++;
    if (outs() !== 16'h0000) begin
      errors++;
      $display("FAIL single_release got %h exp %h", outs(), 16'h0000);
    end
    req_valid = 4'b0000;
  endtask

  task automatic test_round_robin();
    int writes;
    logic [15:0] exp_v;
    writes = 0;
    req_valid = 4'b1111;
    do_reset();
    for (int c = 1; c <= 20; c++) begin
      tick();
      #1;
      if (fifo_wr_en) writes++;
      if (c % 5 != 0)
        exp_v = ev(1'b1, 1'b1, 2'(c / 5), 4'(1 << (c / 5)), 8'(8'h11 * (c / 5 + 1)));
      else
        exp_v = 16'h0000;
      checks++;
      if (outs() !== exp_v) begin
        errors++;
        $display("FAIL rr_cycle%0d got %h exp %h", c, outs(), exp_v);
      end
    end
    checks++;
    if (writes != 16) begin
      errors++;
      $display("FAIL rr_write_count got %0d exp %0d", writes, 16);
    end
    tick();
    #1;
    checks++;
    if (outs() !== ev(1'b1, 1'b1, 2'd0, 4'b0001, 8'h11)) begin
      errors++;
      $display("FAIL rr_wrap got %h exp %h", outs(), ev(1'b1, 1'b1, 2'd0, 4'b0001, 8'h11));
    end
    req_valid = 4'b0000;
  endtask

  task automatic test_owner_drop();
    req_valid = 4'b1100;
    do_reset();
    for (int c = 1; c <= 2; c++) begin
      tick();
      #1;
      checks++;
      if (outs() !== ev(1'b1, 1'b1, 2'd2, 4'b0100, 8'h33)) begin
        errors++;
        $display("FAIL drop_beat%0d got %h exp %h", c, outs(), ev(1'b1, 1'b1, 2'd2, 4'b0100, 8'h33));
      end
    end
    tick();
    req_valid = 4'b1000;
    #1;
    checks++;
    if (outs() !== ev(1'b1, 1'b0, 2'd2, 4'b0000, 8'h00)) begin
      errors++;
      $display("FAIL drop_idle_owner got %h exp %h", outs(), ev(1'b1, 1'b0, 2'd2, 4'b0000, 8'h00));
    end
    tick();
    #1;
    checks++;
    if (outs() !== 16'h0000) begin
      errors++;
      $display("FAIL drop_bubble got %h exp %h", outs(), 16'h0000);
    end
    tick();
    #1;
    checks++;
    if (outs() !== ev(1'b1, 1'b1, 2'd3, 4'b1000, 8'h44)) begin
      errors++;
      $display("FAIL drop_next_owner got %h exp %h", outs(), ev(1'b1, 1'b1, 2'd3, 4'b1000, 8'h44));
    end
    req_valid = 4'b0000;
  endtask

  task automatic test_full_stall();
    req_valid = 4'b0001;
    fifo_full = 1'b0;
    do_reset();
    for (int c = 1; c <= 7; c++) begin
      tick();
      fifo_full = (c >= 3 && c <= 5);
      #1;
      checks++;
      if (c >= 3 && c <= 5) begin
        if (outs() !== ev(1'b1, 1'b0, 2'd0, 4'b0000, 8'h00)) begin
          errors++;
          $display("FAIL stall_cycle%0d got %h exp %h", c, outs(), ev(1'b1, 1'b0, 2'd0, 4'b0000, 8'h00));
        end
      end else begin
        if (outs() !== ev(1'b1, 1'b1, 2'd0, 4'b0001, 8'h11)) begin
          errors++;
          $display("FAIL stall_beat%0d got %h exp %h", c, outs(), ev(1'b1, 1'b1, 2'd0, 4'b0001, 8'h11));
        end
      end
    end
    tick();
    req_valid = 4'b0000;
    #1;
    checks++;
    if (outs() !== 16'h0000) begin
      errors++;
      $display("FAIL stall_release got %h exp %h", outs(), 16'h0000);
    end
  endtask

  task automatic test_full_idle();
    req_valid = 4'b1111;
    fifo_full = 1'b1;
    do_reset();
    for (int c = 0; c <= 4; c++) begin
      if (c > 0) tick();
      if (c == 4) fifo_full = 1'b0;
      #1;
      checks++;
      if (outs() !== 16'h0000) begin
        errors++;
        $display("FAIL full_idle_c%0d got %h exp %h", c, outs(), 16'h0000);
      end
    end
    tick();
    #1;
    checks++;
    if (outs() !== ev(1'b1, 1'b1, 2'd0, 4'b0001, 8'h11)) begin
      errors++;
      $display("FAIL full_idle_grant got %h exp %h", outs(), ev(1'b1, 1'b1, 2'd0, 4'b0001, 8'h11));
    end
    req_valid = 4'b0000;
  endtask

  task automatic test_reset_mid();
    req_valid = 4'b0100;
    do_reset();
    // One full burst to owner 2, bubble, then two beats of the next burst.
    for (int c = 1; c <= 7; c++) tick();
    #1;
    checks++;
    if (outs() !== ev(1'b1, 1'b1, 2'd2, 4'b0100, 8'h33)) begin
      errors++;
      $display("FAIL midrst_beat got %h exp %h", outs(), ev(1'b1, 1'b1, 2'd2, 4'b0100, 8'h33));
    end
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if (outs() !== 16'h0000) begin
      errors++;
      $display("FAIL midrst_async got %h exp %h", outs(), 16'h0000);
    end
    req_valid = 4'b1101;
    tick();
    rst_n = 1'b1;
    tick();
    #1;
    checks++;
    if (outs() !== ev(1'b1, 1'b1, 2'd0, 4'b0001, 8'h11)) begin
      errors++;
      $display("FAIL midrst_first_grant got %h exp %h", outs(), ev(1'b1, 1'b1, 2'd0, 4'b0001, 8'h11));
    end
    req_valid = 4'b0000;
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_owner_drop();
    test_full_stall();
    test_full_idle();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arbiter.md
FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 Parameter N_REQ, default 4: number of producers, fixed at 4 in this revision.
REQ-002 Parameter DW, default 8: data width, matching the 8-bit FIFO word.
REQ-003 Parameter BURST, default 4: maximum beats per grant, legal range 1..8.
REQ-004 Port clk, input, 1: sole clock; all state updates on its rising edge.
REQ-005 Port rst_n, input, 1: reset, asynchronous and active-low.
REQ-006 Port req_valid, input, N_REQ: per-producer word-available flag.
REQ-007 Port req_data, input, N_REQ*DW: producer i's word is at bits [i*DW +: DW].
REQ-008 Port req_ready, output, N_REQ: per-producer beat-accepted flag.
REQ-009 Port fifo_full, input, 1: full flag from the downstream FIFO.
REQ-010 Port fifo_wr_en, output, 1: write strobe to the FIFO.
REQ-011 Port fifo_data, output, DW: write data to the FIFO.
REQ-012 Port grant_id, output, 2: index of the current owner; 0 when idle.
REQ-013 Port busy, output, 1: high while in GRANT.

Function
REQ-014 The FSM SHALL have exactly two states: IDLE and GRANT.
REQ-015 In IDLE with any req_valid bit high and fifo_full low, the block SHALL move to GRANT on the next edge and register owner and grant_id.
REQ-016 The owner SHALL be the first requester with req_valid high, searching round-robin from last_owner+1 (mod 4).
REQ-017 In IDLE with fifo_full high, no grant SHALL be issued.
REQ-018 A beat SHALL transfer when the state is GRANT, req_valid[owner] is high and fifo_full is low.
REQ-019 Beat outputs (combinational from owner, req_valid and fifo_full): fifo_wr_en high, req_ready[owner] high, fifo_data = req_data slice of owner.
REQ-020 req_ready SHALL be low for every non-owner, and for every bit in IDLE.
REQ-021 In GRANT, fifo_full high SHALL stall: no transfer, beat_cnt held, no release.
REQ-022 beat_cnt is 3 bits, SHALL be cleared on grant, and SHALL increment by 1 per transfer.
REQ-023 Release to IDLE SHALL occur when a transfer happens with beat_cnt == BURST-1.
REQ-024 Release to IDLE SHALL also occur when req_valid[owner] is low and fifo_full is low; the idle owner costs one cycle.
REQ-025 On release, last_owner SHALL be set to owner.
REQ-026 The earliest re-grant SHALL be one cycle after release, giving exactly one bubble per grant.
REQ-027 Requesters SHALL be served round-robin: with all 4 requesting continuously, grant order repeats 0,1,2,3 from reset.
REQ-028 req_valid of non-owners SHALL have no effect while in GRANT.
REQ-029 Maximum throughput SHALL be BURST writes per BURST+1 cycles.

Reset
REQ-030 While rst_n is low: state = IDLE, owner = 0, last_owner = 3 (so the first search starts at requester 0), beat_cnt = 0.
REQ-031 While rst_n is low: fifo_wr_en = 0, req_ready = 0, busy = 0, grant_id = 0, fifo_data = 0.
REQ-032 Reset asserted mid-burst SHALL abort the burst immediately; beats already written stay written, and no partial-cycle write is issued.

Structure
REQ-033 N_REQ, BURST and the state encoding (IDLE = 1'b0, GRANT = 1'b1) SHALL live in shared package fifo_arb_pkg.
REQ-034 The round-robin priority search SHALL be a sub-module, rr_pick, that is purely combinational: inputs req[3:0] and last[1:0]; outputs pick[1:0] and any.
REQ-035 fifo_wr_arbiter SHALL instantiate exactly one rr_pick and SHALL not contain the FIFO itself.

Verification
REQ-036 Reset release, only req_valid = 4'b0010 -> GRANT after 1 cycle with grant_id = 1; 4 writes of req_data[15:8]; then IDLE.
REQ-037 All four requesting continuously, BURST = 4 -> grant_id sequence 0,1,2,3,0; 16 writes in 20 cycles.
REQ-038 Owner 2 drops req_valid after 2 beats -> 2 writes, release next cycle, grant passes to 3.
REQ-039 fifo_full asserted for 3 cycles mid-burst -> fifo_wr_en and req_ready low, beat_cnt frozen, burst resumes and completes 4 beats.
REQ-040 fifo_full high in IDLE with req_valid = 4'b1111 -> no grant and busy = 0 until full drops.
REQ-041 rst_n pulled low after 2 beats -> outputs zero asynchronously; after release, the first grant goes to requester 0.
